// File: rtl/mux_scan_pkg.sv
// Shared widths, channel count and FSM state encoding for the round-robin mux scanner.
package mux_scan_pkg;

    localparam int CONTROL_WIDTH = 3;
    localparam int DATA_WIDTH    = 8;
    localparam int NUM_CH        = 1 << CONTROL_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] chan_onehot(input logic [CONTROL_WIDTH-1:0] idx);
        chan_onehot = NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_scan_3_8_if.sv
// Request/grant, mux steering and downstream valid/ready signals of the scanner.
interface mux_scan_3_8_if;
    import mux_scan_pkg::*;

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        ack;
    logic [CONTROL_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0]    mux_out;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_valid;
    logic                     out_ready;

    // Producer / integration side: raises requests, feeds back the mux output, consumes data.
    modport master (
        output req,
        output mux_out,
        output out_ready,
        input  ack,
        input  sel,
        input  out_data,
        input  out_valid
    );

    // Scanner side.
    modport slave (
        input  req,
        input  mux_out,
        input  out_ready,
        output ack,
        output sel,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/mux_3_8.sv
// 8-way, 8-bit combinational multiplexer steered by the scanner's select.
module mux_3_8 (
    input  logic [2:0]      a,
    input  logic [7:0][7:0] d,
    output logic [7:0]      out
);

    assign out = d[a];

endmodule

// File: rtl/rr_pick_8.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick_8
    import mux_scan_pkg::*;
(
    input  logic [NUM_CH-1:0]        req,
    input  logic [CONTROL_WIDTH-1:0] ptr,
    output logic [CONTROL_WIDTH-1:0] idx,
    output logic                     any
);

    logic [CONTROL_WIDTH-1:0] cand [NUM_CH];
    logic [NUM_CH-1:0]        hit;

    // Offset gi from ptr wraps naturally in CONTROL_WIDTH bits.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
        assign cand[gi] = ptr + CONTROL_WIDTH'(gi);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        idx = ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
        any = |req;
    end

endmodule

// File: rtl/mux_scan_3_8.sv
// Round-robin scanner: grants one channel, steers the external mux, captures and hands off the byte.
module mux_scan_3_8
    import mux_scan_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mux_scan_3_8_if.slave bus
);

    state_t                   state_q, state_d;
    logic [CONTROL_WIDTH-1:0] sel_q, sel_d;
    logic [CONTROL_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic [NUM_CH-1:0]        ack_q, ack_d;

    logic [CONTROL_WIDTH-1:0] pick_idx;
    logic                     pick_any;

    rr_pick_8 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    state_d = SELECT;
                end
            end
            // Grant is committed here: req is not re-examined, sel has settled the mux.
            SELECT: begin
                out_data_d  = bus.mux_out;
                out_valid_d = 1'b1;
                ack_d       = chan_onehot(sel_q);
                ptr_d       = sel_q + CONTROL_WIDTH'(1);
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.ack       = ack_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_scan_3_8.sv
// Scoreboard bench for mux_scan_3_8 driving a real mux_3_8 from a per-channel data table.
module tb_mux_scan_3_8;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0][7:0] d_arr;
    exp_t            exp_q[$];
    int              checks   = 0;
    int              failures = 0;
    int              n;

    mux_scan_3_8_if bus ();

    mux_scan_3_8 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mux_3_8 u_mux (
        .a   (bus.sel),
        .d   (d_arr),
        .out (bus.mux_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the next ack pulse; returns the number of rising edges it took.
    task automatic wait_ack(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (bus.ack == 8'h00 && cycles < budget);
        if (bus.ack == 8'h00) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack within %0d cycles", budget);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding expected grant.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ack != 8'h00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack=%0h expected none", bus.ack);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_ack", 32'(bus.ack), 32'(8'h01 << e.ch));
                    check("grant_sel", 32'(bus.sel), 32'(e.ch));
                    check("grant_data", 32'(bus.out_data), 32'(e.data));
                    check("grant_valid", 32'(bus.out_valid), 32'd1);
                    $display("grant ch=%0d data=%02h", bus.sel, bus.out_data);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.req       = 8'h00;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) d_arr[i] = 8'h10 + 8'(i);
        d_arr[5] = 8'hA7;

        @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_data", 32'(bus.out_data), 32'd0);

        @(negedge clk);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("idle_valid", 32'(bus.out_valid), 32'd0);
            check("idle_ack", 32'(bus.ack), 32'd0);
            check("idle_sel", 32'(bus.sel), 32'd0);
        end

        // Single request on channel 5.
        @(negedge clk);
        bus.req = 8'b0010_0000;
        exp_q.push_back('{3'd5, 8'hA7});
        @(posedge clk);
        #1;
        check("single_sel", 32'(bus.sel), 32'd5);
        @(negedge clk);
        bus.req = 8'h00;
        wait_ack(10, n);
        check("single_ack_latency", 32'(n), 32'd1);
        @(posedge clk);
        #1;
        check("single_xfer_done", 32'(bus.out_valid), 32'd0);

        // ptr is now 6: channel 6 must win over 0 and 5.
        @(negedge clk);
        bus.req = 8'b0110_0001;
        exp_q.push_back('{3'd6, 8'h16});
        wait_ack(10, n);

        // ptr is now 7 with channel 7 idle: wrap to 0, then 1.
        @(negedge clk);
        bus.req = 8'b0000_0011;
        exp_q.push_back('{3'd0, 8'h10});
        exp_q.push_back('{3'd1, 8'h11});
        wait_ack(10, n);
        wait_ack(10, n);
        check("wrap_gap", 32'(n), 32'd3);
        @(negedge clk);
        bus.req = 8'h00;

        // Reset returns ptr to 0; full rotation with all channels requesting.
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        d_arr[5] = 8'h15;
        bus.req  = 8'hFF;
        for (int k = 0; k < 9; k++) exp_q.push_back('{3'(k % 8), 8'h10 + 8'(k % 8)});
        for (int k = 0; k < 9; k++) begin
            wait_ack(10, n);
            if (k == 0) check("rot_first_latency", 32'(n), 32'd2);
            else        check("rot_gap", 32'(n), 32'd3);
        end

        // Backpressure on channel 3 (ptr=1).
        @(negedge clk);
        bus.req  = 8'b0000_1000;
        d_arr[3] = 8'h3C;
        exp_q.push_back('{3'd3, 8'h3C});
        @(negedge clk);
        bus.out_ready = 1'b0;
        wait_ack(10, n);
        @(negedge clk);
        bus.req = 8'h00;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data", 32'(bus.out_data), 32'h3C);
            check("bp_sel", 32'(bus.sel), 32'd3);
            check("bp_ack", 32'(bus.ack), 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_xfer_done", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("bp_idle_valid", 32'(bus.out_valid), 32'd0);

        // Reset while in SELECT drops the pending grant.
        @(negedge clk);
        bus.req = 8'h04;
        @(posedge clk);
        #1;
        check("mr_sel_before", 32'(bus.sel), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_ack", 32'(bus.ack), 32'd0);
        check("mr_valid", 32'(bus.out_valid), 32'd0);
        check("mr_sel", 32'(bus.sel), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{3'd2, 8'h12});
        wait_ack(10, n);
        check("mr_regrant_latency", 32'(n), 32'd2);
        @(negedge clk);
        bus.req = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
